// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: encodes RV32I field requests into words and streams them with addresses from a FIFO
module rv_instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [2:0]  req_funct3,
    input  logic        req_funct7b5,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [20:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_addr,
    output logic        err,
    output logic [1:0]  err_cause
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic [31:0] word;
    logic [1:0] cause;
    logic [20:0] im;
    logic acc, push, pop, ok12, ok13, oksh, shift;
    assign im = req_imm;
    assign ok12 = &im[20:11] || ~|im[20:11];
    // 4095 fits 13 bits but is outside the branch range, so it is a range drop
    assign ok13 = (&im[20:12] || ~|im[20:12]) && im[12:0] != 13'h0FFF;
    assign oksh = ~|im[20:5];
    assign shift = req_funct3[1:0] == 2'b01;
    always_comb begin
        word = 32'h0;
        cause = 2'b00;
        case (req_kind)
            3'd0: begin
                word = {im[11:0], req_rs1, req_funct3, req_rd, 7'b0000011};
                cause = ok12 ? 2'b00 : 2'b10;
            end
            3'd1: begin
                word = {im[11:5], req_rs2, req_rs1, req_funct3, im[4:0], 7'b0100011};
                cause = ok12 ? 2'b00 : 2'b10;
            end
            3'd2: word = {1'b0, req_funct7b5, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
            3'd3: begin
                word = {im[12], im[10:5], req_rs2, req_rs1, req_funct3, im[4:1], im[11], 7'b1100011};
                cause = !ok13 ? 2'b10 : im[0] ? 2'b11 : 2'b00;
            end
            3'd4: begin
                word = shift ? {1'b0, req_funct7b5, 5'b0, im[4:0], req_rs1, req_funct3, req_rd, 7'b0010011}
                             : {im[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
                cause = (shift ? oksh : ok12) ? 2'b00 : 2'b10;
            end
            3'd5: begin
                word = {im[20], im[10:1], im[11], im[19:12], req_rd, 7'b1101111};
                cause = im[0] ? 2'b11 : 2'b00;
            end
            default: cause = 2'b01;
        endcase
    end
    assign req_ready = !clear && count < FULL;
    assign instr_valid = count != '0;
    assign instr_data = mem[rp];
    assign acc = req_valid && req_ready;
    assign push = acc && cause == 2'b00;
    assign pop = instr_valid && instr_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            instr_addr <= BASE_ADDR;
            err <= 1'b0;
            err_cause <= 2'b00;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            instr_addr <= BASE_ADDR;
            err <= 1'b0;
            err_cause <= 2'b00;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) begin
                rp <= rp + AW'(1);
                instr_addr <= instr_addr + 32'd4;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (acc && cause != 2'b00) begin
                err <= 1'b1;
                if (!err) err_cause <= cause;
            end
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wp] <= word;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: directed checks of encoding, drops, FIFO flow, wrap, clear and async reset
module tb_rv_instr_encoder;
    logic clk = 1'b0, reset = 1'b1;
    logic clear = 1'b0, req_valid = 1'b0, instr_ready = 1'b0;
    logic b_clear = 1'b0, b_req_valid = 1'b0, b_instr_ready = 1'b0;
    logic [2:0] kind = '0, f3 = '0;
    logic f7 = 1'b0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
    logic [20:0] imm = '0;
    logic req_ready, instr_valid, err, b_req_ready, b_instr_valid, b_err;
    logic [31:0] instr_data, instr_addr, b_instr_data, b_instr_addr;
    logic [1:0] err_cause, b_err_cause;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    rv_instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(kind), .req_funct3(f3), .req_funct7b5(f7), .req_rd(rd), .req_rs1(rs1),
        .req_rs2(rs2), .req_imm(imm), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_addr(instr_addr), .err(err), .err_cause(err_cause));

    rv_instr_encoder #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFFC)) dutb (
        .clk(clk), .reset(reset), .clear(b_clear), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_kind(kind), .req_funct3(f3), .req_funct7b5(f7), .req_rd(rd), .req_rs1(rs1),
        .req_rs2(rs2), .req_imm(imm), .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
        .instr_data(b_instr_data), .instr_addr(b_instr_addr), .err(b_err), .err_cause(b_err_cause));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [2:0] k, input logic [2:0] f, input logic f7b5, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [20:0] i);
        kind = k; f3 = f; f7 = f7b5; rd = d; rs1 = s1; rs2 = s2; imm = i;
    endtask

    task automatic push(input logic [2:0] k, input logic [2:0] f, input logic f7b5, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [20:0] i);
        set(k, f, f7b5, d, s1, s2, i);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic pop();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    function automatic logic [31:0] addi_w(input int n);
        return (32'(n) << 20) | (32'(n) << 7) | 32'h13;
    endfunction

    initial begin
        step();
        step();
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_addr", instr_addr, 32'h0);
        chk("rst_err", {29'b0, err, err_cause}, 32'd0);
        chk("rst_b_addr", b_instr_addr, 32'hFFFF_FFFC);
        #2 reset = 1'b0;
        step();
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        set(3'd0, 3'b010, 1'b0, 5'd6, 5'd9, 5'd0, 21'h1FFFFC);
        req_valid = 1'b1;
        #1 chk("t1_no_bypass", {31'b0, instr_valid}, 32'd0);
        step();
        req_valid = 1'b0;
        chk("t1_valid", {31'b0, instr_valid}, 32'd1);
        chk("t1_data", instr_data, 32'hFFC4A303);
        chk("t1_addr", instr_addr, 32'h0);
        pop();
        chk("t1_empty", {31'b0, instr_valid}, 32'd0);
        chk("t1_addr_inc", instr_addr, 32'h4);

        do_clear();
        chk("t2_clr_addr", instr_addr, 32'h0);
        push(3'd2, 3'b000, 1'b1, 5'd4, 5'd5, 5'd6, 21'd0);
        push(3'd1, 3'b010, 1'b0, 5'd0, 5'd9, 5'd6, 21'd8);
        chk("t2_r_data", instr_data, 32'h40628233);
        chk("t2_r_addr", instr_addr, 32'h0);
        pop();
        chk("t2_sw_data", instr_data, 32'h0064A423);
        chk("t2_sw_addr", instr_addr, 32'h4);
        pop();
        chk("t2_empty", {31'b0, instr_valid}, 32'd0);

        do_clear();
        push(3'd3, 3'b000, 1'b0, 5'd0, 5'd4, 5'd4, 21'h1FFFFC);
        chk("t3_beq", instr_data, 32'hFE420EE3);
        set(3'd3, 3'b000, 1'b0, 5'd0, 5'd4, 5'd4, 21'd3);
        req_valid = 1'b1;
        #1 chk("t3_drop_ready", {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk("t3_err", {31'b0, err}, 32'd1);
        chk("t3_cause", {30'b0, err_cause}, 32'd3);
        pop();
        chk("t3_nopush", {31'b0, instr_valid}, 32'd0);

        do_clear();
        chk("t4_clr_err", {29'b0, err, err_cause}, 32'd0);
        push(3'd5, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 21'h1FFFF8);
        chk("t4_jal", instr_data, 32'hFF9FF06F);
        push(3'd4, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 21'd2048);
        chk("t4_cause_range", {29'b0, err, err_cause}, 32'h6);
        push(3'd7, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 21'd0);
        chk("t4_cause_kept", {29'b0, err, err_cause}, 32'h6);
        push(3'd4, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 21'd3);
        push(3'd4, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 21'd32);
        pop();
        chk("t4_srai", instr_data, 32'h40315093);
        pop();
        chk("t4_shamt_drop", {31'b0, instr_valid}, 32'd0);
        do_clear();
        push(3'd4, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 21'd32);
        chk("t4_shamt_cause", {30'b0, err_cause}, 32'd2);
        push(3'd4, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 21'd3);
        chk("t4_slli", instr_data, 32'h00311093);
        push(3'd3, 3'b000, 1'b0, 5'd0, 5'd4, 5'd4, 21'd4095);
        chk("t4_br_range", {31'b0, instr_valid}, 32'd1);

        do_clear();
        for (int i = 1; i <= 4; i++) push(3'd4, 3'b000, 1'b0, 5'(i), 5'd0, 5'd0, 21'(i));
        chk("t5_full", {31'b0, req_ready}, 32'd0);
        set(3'd4, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 21'd5);
        req_valid = 1'b1;
        instr_ready = 1'b1;
        #1 chk("t5_full_pop", {31'b0, req_ready}, 32'd0);
        step();
        chk("t5_h1", instr_data, addi_w(2));
        chk("t5_a1", instr_addr, 32'h4);
        chk("t5_ready", {31'b0, req_ready}, 32'd1);
        step();
        set(3'd4, 3'b000, 1'b0, 5'd6, 5'd0, 5'd0, 21'd6);
        chk("t5_h2", instr_data, addi_w(3));
        chk("t5_a2", instr_addr, 32'h8);
        step();
        req_valid = 1'b0;
        chk("t5_h3", instr_data, addi_w(4));
        chk("t5_a3", instr_addr, 32'hC);
        step();
        chk("t5_h4", instr_data, addi_w(5));
        chk("t5_a4", instr_addr, 32'h10);
        step();
        chk("t5_h5", instr_data, addi_w(6));
        chk("t5_a5", instr_addr, 32'h14);
        step();
        instr_ready = 1'b0;
        chk("t5_drained", {31'b0, instr_valid}, 32'd0);

        set(3'd0, 3'b010, 1'b0, 5'd6, 5'd9, 5'd0, 21'h1FFFFC);
        b_req_valid = 1'b1;
        step();
        set(3'd1, 3'b010, 1'b0, 5'd0, 5'd9, 5'd6, 21'd8);
        step();
        set(3'd6, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 21'd0);
        step();
        b_req_valid = 1'b0;
        chk("t6_a0", b_instr_addr, 32'hFFFF_FFFC);
        chk("t6_d0", b_instr_data, 32'hFFC4A303);
        chk("t6_illegal", {29'b0, b_err, b_err_cause}, 32'h5);
        b_instr_ready = 1'b1;
        step();
        b_instr_ready = 1'b0;
        chk("t6_a1", b_instr_addr, 32'h0);
        chk("t6_d1", b_instr_data, 32'h0064A423);
        b_clear = 1'b1;
        #1 chk("t6_clr_ready", {31'b0, b_req_ready}, 32'd0);
        step();
        b_clear = 1'b0;
        chk("t6_clr_valid", {31'b0, b_instr_valid}, 32'd0);
        chk("t6_clr_addr", b_instr_addr, 32'hFFFF_FFFC);
        chk("t6_clr_err", {29'b0, b_err, b_err_cause}, 32'd0);

        push(3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd1);
        push(3'd4, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 21'd2);
        pop();
        push(3'd7, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 21'd0);
        chk("t6_pre_rst", {29'b0, instr_valid, err, err_cause[1]}, 32'h6);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("t6_rst_addr", instr_addr, 32'h0);
        chk("t6_rst_err", {29'b0, err, err_cause}, 32'd0);
        #1 reset = 1'b0;
        step();
        step();
        chk("t6_lost", {31'b0, instr_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
